ilm: RTL and testbench

Registered signed approximate multiplier implementing the Improved Logarithmic Multiplier (ILM) algorithm with nearest-power-of-two rounding. It takes two 9-bit two's-complement operands and produces a 17-bit two's-complement approximate product plus an overflow flag. It is a drop-in low-power replacement for an exact 9×9 signed multiplier in error-tolerant datapaths.

---
 rtl/ilm_if.sv | 11 +
 rtl/ilm.sv | 81 ++++++++
 tb/tb_ilm.sv | 128 ++++++++++++
 3 files changed

// File: rtl/ilm_if.sv
// Operand/result bundle for the ILM approximate multiplier.
// The master drives the operands; the slave returns the registered product.
interface ilm_if;
  logic [8:0]  in1;
  logic [8:0]  in2;
  logic [16:0] product;
  logic        carry;

  modport master (output in1, in2, input product, carry);
  modport slave  (input in1, in2, output product, carry);
endinterface

// File: rtl/ilm.sv
// Improved Logarithmic Multiplier: signed 9x9 approximate multiply.
// Each operand is rounded to its nearest power of two, with a single output register.

module ilm_op (
  input  logic [8:0] a,
  output logic [8:0] mag,
  output logic [3:0] r,
  output logic [9:0] q
);
  logic [3:0] k;
  logic       up;
  logic [9:0] pw;

  always_comb begin
    // -256 negates to 9'h100, which still reads correctly as an unsigned magnitude.
    mag = a[8] ? (~a + 9'd1) : a;
    k   = '0;
    up  = 1'b0;
    for (int i = 1; i < 9; i++) begin
      if (mag[i]) begin
        k  = 4'(i);
        up = mag[i-1];
      end
    end
    // Bit just below the leading one decides round-up; ties go up.
    r  = k + {3'b0, up};
    pw = 10'd1 << r;
    q  = {1'b0, mag} - pw;
  end
endmodule

module ilm (
  input  logic  clk,
  input  logic  rst_n,
  ilm_if.slave  bus
);
  localparam int NUM_LANES = 2;

  logic [NUM_LANES-1:0][8:0] opnd;
  logic [NUM_LANES-1:0][8:0] mag;
  logic [NUM_LANES-1:0][3:0] r;
  logic [NUM_LANES-1:0][9:0] q;

  assign opnd = {bus.in2, bus.in1};

  generate
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      ilm_op u_op (.a(opnd[g]), .mag(mag[g]), .r(r[g]), .q(q[g]));
    end
  endgenerate

  logic signed [19:0] q1x, q2x, p, res;
  logic [4:0]         rsum;
  logic               sgn, zero, ovf;

  always_comb begin
    q1x  = {{10{q[0][9]}}, q[0]};
    q2x  = {{10{q[1][9]}}, q[1]};
    // r1+r2 reaches 16, so the shift amount needs 5 bits.
    rsum = {1'b0, r[0]} + {1'b0, r[1]};
    p    = (20'sd1 <<< rsum) + (q1x <<< r[1]) + (q2x <<< r[0]);
    sgn  = bus.in1[8] ^ bus.in2[8];
    zero = (mag[0] == '0) || (mag[1] == '0);
    res  = sgn ? -p : p;
    ovf  = (res > 20'sd65535) || (res < -20'sd65536);
    if (zero) begin
      res = '0;
      ovf = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.product <= '0;
      bus.carry   <= 1'b0;
    end else begin
      bus.product <= res[16:0];
      bus.carry   <= ovf;
    end
  end
endmodule

// File: tb/tb_ilm.sv
// Scoreboarded bench for ilm: the driver queues model results, the monitor
// pops one per cycle and compares against the registered outputs.
module tb_ilm;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  ilm_if bus();

  ilm dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [17:0] sb[$];

  // Rounded exponent: nearest power of two, ties rounded up.
  function automatic int rnd(input int m);
    int k = 0;
    while ((2 << k) <= m) k++;
    if (k > 0 && m >= (1 << k) + (1 << (k - 1))) return k + 1;
    return k;
  endfunction

  // Approximate product = exact product minus the residual cross term.
  function automatic logic [17:0] model(input logic [8:0] a, input logic [8:0] b);
    int xa, xb, m1, m2, q1, q2, pp, rr;
    logic [31:0] rb;
    logic cy;
    xa = $signed(a);
    xb = $signed(b);
    m1 = (xa < 0) ? -xa : xa;
    m2 = (xb < 0) ? -xb : xb;
    if (m1 == 0 || m2 == 0) return 18'd0;
    q1 = m1 - (1 << rnd(m1));
    q2 = m2 - (1 << rnd(m2));
    pp = m1 * m2 - q1 * q2;
    rr = ((xa < 0) != (xb < 0)) ? -pp : pp;
    rb = rr;
    cy = (rr > 65535) || (rr < -65536);
    return {cy, rb[16:0]};
  endfunction

  task automatic chk(input string nm, input logic [17:0] act, input logic [17:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got carry=%0b product=%h, expected carry=%0b product=%h",
               nm, act[17], act[16:0], exp[17], exp[16:0]);
    end
  endtask

  task automatic issue(input int a, input int b);
    logic [8:0] va, vb;
    @(posedge clk);
    #1;
    va = 9'(a);
    vb = 9'(b);
    bus.in1 = va;
    bus.in2 = vb;
    sb.push_back(model(va, vb));
  endtask

  // Monitor: a result is due after an edge only if it was queued before that edge.
  initial begin
    logic pending;
    logic [17:0] e;
    forever begin
      @(posedge clk);
      pending = (sb.size() > 0);
      #3;
      if (pending && rst_n) begin
        e = sb.pop_front();
        chk("stream", {bus.carry, bus.product}, e);
      end
    end
  end

  int da[] = '{15, 20, 8, 50, 25, 129, 1, 255, 96, -8, 8, -8, -255, 0, -256, 0,
               -256, -256, 255, 256, 16, 4};
  int db[] = '{5, 4, 2, 7, 6, 65, 1, 255, 159, 9, -9, -9, 255, 18, 0, 0,
               -256, 255, -256, 255, 4, 64};

  initial begin
    bus.in1 = 9'd0;
    bus.in2 = 9'd0;
    #1 rst_n = 1'b0;
    #2 chk("reset_state", {bus.carry, bus.product}, 18'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Spec examples pinned to literal results, independent of the model.
    checks++;
    if (model(9'd15, 9'd5) !== 18'd76) begin errors++; $display("FAIL model_15x5"); end

    for (int i = 0; i < da.size(); i++) issue(da[i], db[i]);
    for (int i = 0; i < 20000; i++) begin
      int a, b;
      a = $urandom_range(0, 511);
      b = $urandom_range(0, 511);
      if ($urandom_range(0, 15) == 0) a = ($urandom_range(0, 1) != 0) ? 256 : 0;
      issue(a, b);
    end

    repeat (3) @(posedge clk);
    #4;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d queued, expected 0", sb.size());
    end

    // Mid-cycle async reset, then one capture of 15x5.
    @(posedge clk);
    #1;
    bus.in1 = 9'd15;
    bus.in2 = 9'd5;
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {bus.carry, bus.product}, 18'd0);
    @(posedge clk);
    #1 chk("reset_hold", {bus.carry, bus.product}, 18'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1 chk("after_reset", {bus.carry, bus.product}, {1'b0, 17'd76});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
